// File: rtl/tx_preamble_inserter_if.sv
// Framer stream bundle: sample strobe/gating, start, FIFO head/pop, framed output and status.
// slave is the framer side; master is whoever drives ticks and the payload FIFO.
interface tx_preamble_inserter_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         input_strobe;
  logic                         enable;
  logic                         start;
  logic signed [DATA_WIDTH-1:0] payload_I;
  logic signed [DATA_WIDTH-1:0] payload_Q;
  logic                         payload_empty;
  logic                         payload_last;
  logic                         payload_rd;
  logic signed [DATA_WIDTH-1:0] I_out;
  logic signed [DATA_WIDTH-1:0] Q_out;
  logic                         output_strobe;
  logic                         Providing_Preamble;
  logic                         Providing_Stream;
  logic                         busy;
  logic                         done;
  logic                         underrun;

  modport master (
    output input_strobe, enable, start, payload_I, payload_Q, payload_empty, payload_last,
    input  payload_rd, I_out, Q_out, output_strobe, Providing_Preamble, Providing_Stream,
           busy, done, underrun
  );

  modport slave (
    input  input_strobe, enable, start, payload_I, payload_Q, payload_empty, payload_last,
    output payload_rd, I_out, Q_out, output_strobe, Providing_Preamble, Providing_Stream,
           busy, done, underrun
  );
endinterface

// File: rtl/tx_preamble_inserter.sv
// 802.11a framer: 160 STS + 160 LTS samples, then payload I/Q until payload_last.
// Latency: each sample is registered one cycle after its qualified tick.
// Backpressure: none upstream; empty FIFO in payload yields a fill sample and sets underrun.
module tx_preamble_inserter #(
  parameter int DATA_WIDTH       = 16,
  parameter bit ZERO_ON_UNDERRUN = 1'b1
) (
  input logic                CLK,
  input logic                s_RST,
  tx_preamble_inserter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, STS, LTS_GI, LTS, PAYLOAD} state_t;

  // Annex G time-domain training symbols scaled by 2^13, rounded.
  localparam int STS_I [16] = '{377, -1081, -106, 1171, 754, 1171, -106, -1081,
                                377, 16, -647, -106, 0, -106, -647, 16};
  localparam int STS_Q [16] = '{377, 16, -647, -106, 0, -106, -647, 16,
                                377, -1081, -106, 1171, 754, 1171, -106, -1081};
  localparam int LTS_I [64] = '{
    1278, -41, 328, 795, 172, 492, -942, -311, 803, 434, 8, -1122, 197, 483, -180, 975,
    508, 303, -467, -1073, 672, 573, -492, -459, -287, -999, -1040, 614, -25, -754, 754, 98,
    -1278, 98, 754, -754, -25, 614, -1040, -999, -287, -459, -492, 573, 672, -1073, -467, 303,
    508, 975, -180, 483, 197, -1122, 8, 434, 803, -311, -942, 492, 172, 795, 328, -41};
  localparam int LTS_Q [64] = '{
    0, -983, -909, 680, 229, -721, -451, -868, -213, 33, -942, -385, -483, -123, 1319, -33,
    508, -803, -319, -532, -754, -115, -664, 180, 1237, 139, 172, 606, -442, -942, -868, -803,
    0, 803, 868, 942, 442, -606, -172, -139, -1237, -180, 664, 115, 754, 532, 319, 803,
    -508, 33, -1319, 123, 483, 385, 942, -33, 213, 868, 451, 721, -229, -680, 909, 983};

  state_t                       state;
  logic [8:0]                   n;
  logic                         tick;
  logic signed [DATA_WIDTH-1:0] pre_i;
  logic signed [DATA_WIDTH-1:0] pre_q;
  logic signed [DATA_WIDTH-1:0] last_i;
  logic signed [DATA_WIDTH-1:0] last_q;

  assign tick           = bus.input_strobe & bus.enable;
  assign bus.busy       = (state != IDLE);
  assign bus.payload_rd = (state == PAYLOAD) && tick && !bus.payload_empty;

  // Both LTS regions index by n[5:0]: n-128 over 160..191 and (n-192) mod 64 over 192..319.
  always_comb begin
    if (state == STS) begin
      pre_i = DATA_WIDTH'(STS_I[n[3:0]]);
      pre_q = DATA_WIDTH'(STS_Q[n[3:0]]);
    end else begin
      pre_i = DATA_WIDTH'(LTS_I[n[5:0]]);
      pre_q = DATA_WIDTH'(LTS_Q[n[5:0]]);
    end
  end

  always_ff @(posedge CLK or negedge s_RST) begin
    if (!s_RST) begin
      state                  <= IDLE;
      n                      <= '0;
      bus.I_out              <= '0;
      bus.Q_out              <= '0;
      bus.output_strobe      <= 1'b0;
      bus.Providing_Preamble <= 1'b0;
      bus.Providing_Stream   <= 1'b0;
      bus.done               <= 1'b0;
      bus.underrun           <= 1'b0;
      last_i                 <= '0;
      last_q                 <= '0;
    end else begin
      bus.output_strobe <= 1'b0;
      bus.done          <= 1'b0;
      case (state)
        IDLE: begin
          bus.Providing_Preamble <= 1'b0;
          bus.Providing_Stream   <= 1'b0;
          if (bus.start) begin
            state        <= STS;
            n            <= '0;
            bus.underrun <= 1'b0;
            last_i       <= '0;
            last_q       <= '0;
          end
        end
        STS, LTS_GI, LTS: begin
          if (tick) begin
            bus.I_out              <= pre_i;
            bus.Q_out              <= pre_q;
            bus.output_strobe      <= 1'b1;
            bus.Providing_Preamble <= 1'b1;
            bus.Providing_Stream   <= 1'b0;
            n                      <= (n == 9'd319) ? 9'd0 : n + 9'd1;
            if (n == 9'd159)      state <= LTS_GI;
            else if (n == 9'd191) state <= LTS;
            else if (n == 9'd319) state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (tick) begin
            bus.output_strobe      <= 1'b1;
            bus.Providing_Preamble <= 1'b0;
            bus.Providing_Stream   <= 1'b1;
            if (!bus.payload_empty) begin
              bus.I_out <= bus.payload_I;
              bus.Q_out <= bus.payload_Q;
              last_i    <= bus.payload_I;
              last_q    <= bus.payload_Q;
              if (bus.payload_last) begin
                state    <= IDLE;
                bus.done <= 1'b1;
              end
            end else begin
              bus.underrun <= 1'b1;
              bus.I_out    <= ZERO_ON_UNDERRUN ? '0 : last_i;
              bus.Q_out    <= ZERO_ON_UNDERRUN ? '0 : last_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_preamble_inserter.sv
// Scoreboard bench for tx_preamble_inserter: expected samples queued per tick, checked per output_strobe.
module tb_tx_preamble_inserter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tx_preamble_inserter_if #(.DATA_WIDTH(16)) bus ();

  tx_preamble_inserter #(.DATA_WIDTH(16), .ZERO_ON_UNDERRUN(1'b1)) dut (
    .CLK  (clk),
    .s_RST(rst_n),
    .bus  (bus)
  );

  typedef struct {int i; int q; bit chk_iq; bit pre; bit stream; bit dn;} exp_t;
  typedef struct {int i; int q; bit last;} smp_t;

  localparam int STS_I [16] = '{377, -1081, -106, 1171, 754, 1171, -106, -1081,
                                377, 16, -647, -106, 0, -106, -647, 16};
  localparam int STS_Q [16] = '{377, 16, -647, -106, 0, -106, -647, 16,
                                377, -1081, -106, 1171, 754, 1171, -106, -1081};

  exp_t exp_q[$];
  smp_t fifo[$];
  int   n_chk = 0;
  int   n_bad = 0;
  int   n_strobe, n_pre, n_stream, n_done, n_rd, done_idx;
  int   cap_i [400];
  int   cap_q [400];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Output monitor: pops one expectation per emitted sample.
  always @(negedge clk) begin
    exp_t e;
    if (bus.payload_rd) n_rd++;
    if (bus.output_strobe) begin
      if (n_strobe < 400) begin
        cap_i[n_strobe] = bus.I_out;
        cap_q[n_strobe] = bus.Q_out;
      end
      if (bus.Providing_Preamble) n_pre++;
      if (bus.Providing_Stream) n_stream++;
      if (bus.done) begin
        n_done++;
        done_idx = n_strobe;
      end
      if (exp_q.size() == 0) begin
        chk("spurious_strobe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        if (e.chk_iq) begin
          chk("sample_I", bus.I_out, e.i);
          chk("sample_Q", bus.Q_out, e.q);
        end
        chk("prov_preamble", bus.Providing_Preamble, e.pre);
        chk("prov_stream", bus.Providing_Stream, e.stream);
        chk("done", bus.done, e.dn);
      end
      n_strobe++;
    end
  end

  task automatic clear_stats();
    n_strobe = 0; n_pre = 0; n_stream = 0; n_done = 0; n_rd = 0; done_idx = -1;
  endtask

  task automatic drive_head();
    if (fifo.size() > 0) begin
      bus.payload_I     = 16'(fifo[0].i);
      bus.payload_Q     = 16'(fifo[0].q);
      bus.payload_last  = fifo[0].last;
      bus.payload_empty = 1'b0;
    end else begin
      bus.payload_I     = 16'sh7777;
      bus.payload_Q     = 16'sh7777;
      bus.payload_last  = 1'b1;
      bus.payload_empty = 1'b1;
    end
  endtask

  task automatic load(input int cnt, input bit with_last);
    for (int k = 0; k < cnt; k++) begin
      smp_t s;
      s.i    = int'($urandom_range(0, 65535)) - 32768;
      s.q    = int'($urandom_range(0, 65535)) - 32768;
      s.last = with_last && (k == cnt - 1);
      fifo.push_back(s);
    end
    drive_head();
  endtask

  task automatic gap();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input bit exp_rd, input string tag);
    bus.input_strobe = 1'b1;
    #1;
    chk(tag, bus.payload_rd, exp_rd);
    @(posedge clk);
    #1;
    bus.input_strobe = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic tick_pre(input int n);
    exp_t e;
    e.i = 0; e.q = 0; e.chk_iq = 1'b0; e.pre = 1'b1; e.stream = 1'b0; e.dn = 1'b0;
    if (n < 160) begin
      e.i = STS_I[n % 16]; e.q = STS_Q[n % 16]; e.chk_iq = 1'b1;
    end else if (n == 160 || n == 224 || n == 288) begin
      e.i = -1278; e.chk_iq = 1'b1;
    end else if (n == 192 || n == 256) begin
      e.i = 1278; e.chk_iq = 1'b1;
    end
    exp_q.push_back(e);
    strobe(1'b0, "rd_in_preamble");
    gap();
  endtask

  task automatic tick_pay();
    exp_t e;
    bit   have;
    have = (fifo.size() > 0);
    e.chk_iq = 1'b1; e.pre = 1'b0; e.stream = 1'b1;
    if (have) begin
      e.i = fifo[0].i; e.q = fifo[0].q; e.dn = fifo[0].last;
    end else begin
      e.i = 0; e.q = 0; e.dn = 1'b0;
    end
    exp_q.push_back(e);
    strobe(have, "rd_in_payload");
    if (have) void'(fifo.pop_front());
    drive_head();
    gap();
  endtask

  task automatic preamble(input int last_n, input bit hooks);
    for (int n = 0; n <= last_n; n++) begin
      if (hooks && n == 170) begin
        bus.enable = 1'b0;
        for (int g = 0; g < 3; g++) begin
          strobe(1'b0, "rd_gated");
          gap();
        end
        chk("gated_no_strobe", n_strobe, 170);
        bus.enable = 1'b1;
      end
      tick_pre(n);
      if (hooks && n == 50) begin
        do_start();
        chk("busy_after_ignored_start", bus.busy, 1);
      end
    end
  endtask

  task automatic chk_reset();
    chk("rst_I_out", bus.I_out, 0);
    chk("rst_Q_out", bus.Q_out, 0);
    chk("rst_strobe", bus.output_strobe, 0);
    chk("rst_prov_pre", bus.Providing_Preamble, 0);
    chk("rst_prov_stream", bus.Providing_Stream, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_underrun", bus.underrun, 0);
    chk("rst_payload_rd", bus.payload_rd, 0);
  endtask

  initial begin
    bus.input_strobe = 1'b0;
    bus.enable       = 1'b1;
    bus.start        = 1'b0;
    drive_head();
    clear_stats();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame A: start coincident with an idle tick, ignored restart, gating, 5-sample payload
    clear_stats();
    bus.start        = 1'b1;
    bus.input_strobe = 1'b1;
    @(posedge clk);
    #1;
    bus.start        = 1'b0;
    bus.input_strobe = 1'b0;
    gap();
    chk("busy_after_start", bus.busy, 1);
    chk("idle_tick_no_strobe", n_strobe, 0);
    preamble(319, 1'b1);
    chk("pre_strobes", n_pre, 320);
    chk("pre_total", n_strobe, 320);
    chk("sts16_I", cap_i[16], cap_i[0]);
    chk("sts16_Q", cap_q[16], cap_q[0]);
    chk("lts224_I", cap_i[224], cap_i[160]);
    chk("lts288_I", cap_i[288], cap_i[160]);
    chk("lts288_Q", cap_q[288], cap_q[160]);
    load(5, 1'b1);
    for (int k = 0; k < 5; k++) tick_pay();
    chk("a_rd_count", n_rd, 5);
    chk("a_stream_count", n_stream, 5);
    chk("a_done_count", n_done, 1);
    chk("a_done_idx", done_idx, 324);
    chk("a_busy_after", bus.busy, 0);
    chk("a_underrun", bus.underrun, 0);
    chk("a_queue_drained", exp_q.size(), 0);

    // Frame B: two empty payload slots, last asserted on the empty head
    clear_stats();
    do_start();
    preamble(319, 1'b0);
    load(2, 1'b0);
    for (int k = 0; k < 4; k++) tick_pay();
    chk("b_underrun_set", bus.underrun, 1);
    load(3, 1'b1);
    for (int k = 0; k < 3; k++) tick_pay();
    chk("b_underrun_sticky", bus.underrun, 1);
    chk("b_rd_count", n_rd, 5);
    chk("b_total", n_strobe, 327);
    chk("b_done_idx", done_idx, 326);
    chk("b_done_count", n_done, 1);

    // Frame C: start clears underrun, then reset aborts at n=100
    clear_stats();
    do_start();
    chk("c_underrun_cleared", bus.underrun, 0);
    preamble(99, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset();
    chk("c_queue_drained", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame D: fresh frame after the abort
    do_start();
    preamble(319, 1'b0);
    load(5, 1'b1);
    for (int k = 0; k < 5; k++) tick_pay();
    chk("d_done_count", n_done, 1);
    chk("d_done_idx", done_idx, 424);
    chk("d_rd_count", n_rd, 5);
    chk("d_busy_after", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
